// File: rtl/ifu_pkg.sv
// Shared configuration for the fetch unit: default widths, reset PC and FSM encoding.
package ifu_pkg;

  localparam int CFG_ADDR_WIDTH = 32;
  localparam int CFG_INST_WIDTH = 32;
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_RST_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one RAM read at a time, holds the
// returned word for decode and discards fetches made stale by a redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int                    INST_WIDTH = CFG_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RST_PC     = CFG_RST_PC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic                  i_ram_rd_ready,
  input  logic                  i_ram_rd_valid,
  input  logic [INST_WIDTH-1:0] i_ram_rd_data,
  input  logic                  i_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
  output logic                  o_idu_valid,
  input  logic                  i_idu_ready,
  output logic [INST_WIDTH-1:0] o_idu_inst,
  output logic [ADDR_WIDTH-1:0] o_idu_pc,
  output ifu_state_e            o_dbg_state
);

  // Handshakes: a beat moves on a side only in a cycle where both its valid
  // (o_ram_rd_en / o_idu_valid) and ready (i_ram_rd_ready / i_idu_ready) are high;
  // i_ram_rd_valid is a one-cycle response with no back-pressure.

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic                  valid_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;

  logic                  xfer;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] jmp_target;
  logic                  jmp_pc_unused;

  assign jmp_target    = {i_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
  assign jmp_pc_unused = ^i_jmp_pc[1:0];

  // A redirect cycle masks valid so it can never be a transfer.
  assign o_idu_valid = valid_q & ~i_jmp_en;
  assign xfer        = o_idu_valid & i_idu_ragged_guard();

  function automatic logic i_idu_ragged_guard();
    return i_idu_ready;
  endfunction

  assign capture = (state_q == S_WAIT) & i_ram_rd_valid & ~kill_q & ~i_jmp_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RST_PC;
      kill_q    <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      valid_q <= (state_d == S_HOLD);
      if (capture) begin
        inst_q    <= i_ram_rd_data;
        inst_pc_q <= pc_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (i_ram_rd_ready) begin
          state_d = S_WAIT;
          kill_d  = i_jmp_en;
        end
      end
      S_WAIT: begin
        if (i_ram_rd_valid) begin
          kill_d  = 1'b0;
          state_d = capture ? S_HOLD : S_REQ;
        end else if (i_jmp_en) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_jmp_en || xfer) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_jmp_en) begin
      pc_d = jmp_target;
    end else if (xfer) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    o_ram_rd_en   = (state_q == S_REQ);
    o_ram_rd_addr = pc_q;
    o_idu_inst    = inst_q;
    o_idu_pc      = inst_pc_q;
    o_dbg_state   = state_q;
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: latency-programmable RAM model, scoreboard of
// expected {pc, inst} beats, and directed plus random redirect scenarios.
module tb_ifu;
  import ifu_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic          clk;
  logic          rst;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_ready;
  logic          ram_rd_valid;
  logic [IW-1:0] ram_rd_data;
  logic          jmp_en;
  logic [AW-1:0] jmp_pc;
  logic          idu_valid;
  logic          idu_ready;
  logic [IW-1:0] idu_inst;
  logic [AW-1:0] idu_pc;
  ifu_state_e    dbg_state;

  ifu #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RST_PC(RPC)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_ram_rd_en(ram_rd_en), .o_ram_rd_addr(ram_rd_addr),
    .i_ram_rd_ready(ram_rd_ready), .i_ram_rd_valid(ram_rd_valid),
    .i_ram_rd_data(ram_rd_data),
    .i_jmp_en(jmp_en), .i_jmp_pc(jmp_pc),
    .o_idu_valid(idu_valid), .i_idu_ready(idu_ready),
    .o_idu_inst(idu_inst), .o_idu_pc(idu_pc),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] acc_log[$];
  int          xfer_log[$];
  int          cyc = 0;
  bit          kill_pend = 0;
  logic [31:0] exp_addr = RPC;
  logic [63:0] mon_e;

  int          ram_lat = 1;
  bit          ram_rand_rdy = 0;
  bit          ram_pend = 0;
  int          ram_cnt = 0;
  logic [31:0] ram_addr = '0;
  bit          resp_real = 0;
  bit          inject_late = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int xfer_at(input int i);
    if (i < xfer_log.size()) return xfer_log[i];
    return -1000;
  endfunction

  // RAM model: one response per accepted request, ram_lat cycles later.
  initial begin
    ram_rd_ready = 1'b0;
    ram_rd_valid = 1'b0;
    ram_rd_data  = '0;
    forever begin
      @(negedge clk);
      ram_rd_valid = 1'b0;
      resp_real    = 0;
      if (rst) begin
        ram_pend = 0;
      end else if (ram_pend) begin
        ram_cnt--;
        if (ram_cnt <= 0) begin
          ram_rd_valid = 1'b1;
          ram_rd_data  = mem_word(ram_addr);
          resp_real    = 1;
          ram_pend     = 0;
        end
      end
      if (inject_late) begin
        ram_rd_valid = 1'b1;
        ram_rd_data  = 32'hDEAD_BEEF;
        inject_late  = 0;
      end
      ram_rd_ready = ram_rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!rst && ram_rd_en && ram_rd_ready) begin
        ram_pend = 1;
        ram_cnt  = ram_lat;
        ram_addr = ram_rd_addr;
      end
    end
  end

  // scoreboard / monitor, sampled mid-low-phase
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        exp_q.delete();
        kill_pend = 0;
        exp_addr  = RPC;
      end else begin
        check("idu_valid", {63'd0, idu_valid}, {63'd0, (exp_q.size() != 0) && !jmp_en});
        if (ram_rd_en && ram_rd_ready) begin
          acc_log.push_back(ram_rd_addr);
          check("req_addr", {32'd0, ram_rd_addr}, {32'd0, exp_addr});
        end
        if (idu_valid && idu_ready) begin
          xfer_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("xfer_unexpected", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("idu_pc", {32'd0, idu_pc}, {32'd0, mon_e[63:32]});
            check("idu_inst", {32'd0, idu_inst}, {32'd0, mon_e[31:0]});
            exp_addr = mon_e[63:32] + 32'd4;
          end
        end
        if (jmp_en) begin
          exp_addr = {jmp_pc[31:2], 2'b00};
          exp_q.delete();
        end
        if (resp_real) begin
          if (kill_pend || jmp_en) kill_pend = 0;
          else exp_q.push_back({ram_addr, ram_rd_data});
        end else if (jmp_en && ram_pend) begin
          kill_pend = 1;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_log.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (acc_log.size() < n) check("acc_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_xfer(input int n);
    int t = 0;
    while (xfer_log.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (xfer_log.size() < n) check("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!idu_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!idu_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {63'd0, ram_rd_en}, 64'd0);
    check({tag, "_rd_addr"}, {32'd0, ram_rd_addr}, {32'd0, RPC});
    check({tag, "_valid"}, {63'd0, idu_valid}, 64'd0);
    check({tag, "_inst"}, {32'd0, idu_inst}, 64'd0);
    check({tag, "_pc"}, {32'd0, idu_pc}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, S_IDLE});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ba, bx, ac, n, v;
    rst = 1'b1;
    jmp_en = 1'b0;
    jmp_pc = '0;
    idu_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("rst0");

    // straight-line fetch, L=1, decode always ready
    @(negedge clk);
    ba = acc_log.size();
    bx = xfer_log.size();
    rst = 1'b0;
    #2;
    check("first_req_idle", {63'd0, ram_rd_en}, 64'd0);
    @(negedge clk);
    check("first_req", {63'd0, ram_rd_en}, 64'd1);
    wait_xfer(bx + 3);
    check("t1_addr0", {32'd0, acc_at(ba)}, 64'h8000_0000);
    check("t1_addr1", {32'd0, acc_at(ba + 1)}, 64'h8000_0004);
    check("t1_addr2", {32'd0, acc_at(ba + 2)}, 64'h8000_0008);
    check("t1_rate01", 64'(xfer_at(bx + 1) - xfer_at(bx)), 64'd3);
    check("t1_rate12", 64'(xfer_at(bx + 2) - xfer_at(bx + 1)), 64'd3);

    // decode stall while the word at 0x8000_000C is held
    idu_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", {63'd0, idu_valid}, 64'd1);
      check("stall_inst", {32'd0, idu_inst}, {32'd0, mem_word(32'h8000_000C)});
      check("stall_pc", {32'd0, idu_pc}, 64'h8000_000C);
      check("stall_rd_en", {63'd0, ram_rd_en}, 64'd0);
      @(negedge clk);
    end
    idu_ready = 1'b1;
    ram_lat = 4;
    wait_acc(ba + 5);
    check("stall_next", {32'd0, acc_at(ba + 4)}, 64'h8000_0010);

    // redirect while waiting on a 4-cycle response
    jmp_en = 1'b1;
    jmp_pc = 32'h8000_0102;
    @(negedge clk);
    jmp_en = 1'b0;
    v = 0;
    while (acc_log.size() < ba + 6 && v < 50) begin
      if (idu_valid) v += 100;
      v++;
      @(negedge clk);
    end
    check("wait_kill_no_valid", 64'(v >= 100), 64'd0);
    check("wait_kill_next", {32'd0, acc_at(ba + 5)}, 64'h8000_0100);
    ram_lat = 1;

    // redirect in hold with decode ready the same cycle
    n = xfer_log.size();
    wait_xfer(n + 1);
    idu_ready = 1'b0;
    wait_valid();
    n = xfer_log.size();
    ac = acc_log.size();
    jmp_en = 1'b1;
    jmp_pc = 32'h8000_0200;
    idu_ready = 1'b1;
    #2;
    check("hold_jmp_valid", {63'd0, idu_valid}, 64'd0);
    @(negedge clk);
    jmp_en = 1'b0;
    check("hold_jmp_no_xfer", 64'(xfer_log.size()), 64'(n));
    wait_acc(ac + 1);
    check("hold_jmp_next", {32'd0, acc_at(ac)}, 64'h8000_0200);

    // PC wrap past the top of the address space
    n = xfer_log.size();
    wait_xfer(n + 1);
    idu_ready = 1'b0;
    wait_valid();
    ac = acc_log.size();
    jmp_en = 1'b1;
    jmp_pc = 32'hFFFF_FFFF;
    idu_ready = 1'b1;
    @(negedge clk);
    jmp_en = 1'b0;
    wait_acc(ac + 2);
    check("wrap_top", {32'd0, acc_at(ac)}, 64'hFFFF_FFFC);
    check("wrap_zero", {32'd0, acc_at(ac + 1)}, 64'h0000_0000);

    // random ready/back-pressure/redirect traffic
    ram_rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) ram_lat = $urandom_range(1, 3);
      idu_ready = ($urandom_range(0, 3) != 0);
      jmp_en    = ($urandom_range(0, 11) == 0);
      jmp_pc    = $urandom();
      @(negedge clk);
    end
    jmp_en = 1'b0;
    idu_ready = 1'b1;
    ram_rand_rdy = 0;
    ram_lat = 6;
    n = xfer_log.size();
    wait_xfer(n + 1);

    // reset while a response is outstanding, then late responses
    ac = acc_log.size();
    wait_acc(ac + 1);
    check("pre_rst_state", {62'd0, dbg_state}, {62'd0, S_WAIT});
    rst = 1'b1;
    @(negedge clk);
    #1 inject_late = 1;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk);
    ac = acc_log.size();
    n = xfer_log.size();
    rst = 1'b0;
    #1 inject_late = 1;
    #1 check("late_idle_valid", {63'd0, idu_valid}, 64'd0);
    @(negedge clk);
    #2 check("late_req_valid", {63'd0, idu_valid}, 64'd0);
    wait_acc(ac + 1);
    check("rst_first_req", {32'd0, acc_at(ac)}, {32'd0, RPC});
    wait_xfer(n + 1);
    check("rst_no_extra_acc", 64'(acc_log.size() - ac), 64'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
